// File: rtl/motor_pkg.sv
// Shared types and constants for the e-bike phase drive generator.
// Contents:
//   phase_state_t  per-phase drive state (FWD, REV, HIZ, BRK)
//   PWM_W_DEFAULT  default PWM counter / duty width
//   HALL_S1..S6    the six legal hall codes {G,Y,B}, in forward rotation order
//   phase_drive()  maps a phase state plus the pwm level to {high, low}
package motor_pkg;

  typedef enum logic [1:0] {
    FWD,
    REV,
    HIZ,
    BRK
  } phase_state_t;

  localparam int unsigned PWM_W_DEFAULT = 11;

  localparam logic [2:0] HALL_S1 = 3'b101;
  localparam logic [2:0] HALL_S2 = 3'b100;
  localparam logic [2:0] HALL_S3 = 3'b110;
  localparam logic [2:0] HALL_S4 = 3'b010;
  localparam logic [2:0] HALL_S5 = 3'b011;
  localparam logic [2:0] HALL_S6 = 3'b001;

  // Returns {high, low}. No state can produce 2'b11, so the two switches of
  // one phase are never commanded on together.
  function automatic logic [1:0] phase_drive(input phase_state_t st, input logic pwm);
    logic [1:0] hl;
    hl = 2'b00;
    case (st)
      FWD:     hl = {pwm, ~pwm};
      REV:     hl = {~pwm, pwm};
      BRK:     hl = {1'b0, pwm};
      default: hl = 2'b00;
    endcase
    return hl;
  endfunction

endpackage

// File: rtl/pwm_gen.sv
// Free-running PWM generator.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   duty        high-side on-count per period, reloaded once per period
//   pwm         combinational (cnt < dutyL)
//   pwm_sync    registered; high in the cycle whose registered outputs
//               correspond to cnt == 0
module pwm_gen
  import motor_pkg::*;
#(
  parameter int unsigned PWM_W = PWM_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PWM_W-1:0] duty,
  output logic             pwm,
  output logic             pwm_sync
);

  logic [PWM_W-1:0] cnt;
  logic [PWM_W-1:0] duty_l;

  // duty is captured on the last count of a period so it applies from cnt == 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      duty_l   <= '0;
      pwm_sync <= 1'b0;
    end else begin
      cnt      <= cnt + 1'b1;
      pwm_sync <= (cnt == '0);
      if (cnt == '1) begin
        duty_l <= duty;
      end
    end
  end

  always_comb begin
    pwm = (cnt < duty_l);
  end

endmodule

// File: rtl/phase_drive_gen.sv
// Raw six-switch gate command generator: PWM plus six-step hall commutation
// plus brake. Dead time is inserted downstream.
// Ports:
//   clk, rst_n                  50 MHz clock, asynchronous active-low reset
//   duty                        PWM on-count per period
//   hallGrn, hallYel, hallBlu   raw asynchronous hall inputs
//   brake_n                     active-low brake request (synchronous)
//   highU..lowW                 registered gate commands
//   pwmSync                     pulse on the first cycle of each PWM period
//   hallErr                     registered, high while the hall code is 000/111
// Build option: HALL_DEBOUNCE_EN requires a synchronized hall code to be
// stable for 4 clocks before it is loaded into the code register.
module phase_drive_gen
  import motor_pkg::*;
#(
  parameter int unsigned PWM_W = PWM_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PWM_W-1:0] duty,
  input  logic             hallGrn,
  input  logic             hallYel,
  input  logic             hallBlu,
  input  logic             brake_n,
  output logic             highU,
  output logic             lowU,
  output logic             highV,
  output logic             lowV,
  output logic             highW,
  output logic             lowW,
  output logic             pwmSync,
  output logic             hallErr
);

  logic         pwm;
  logic [2:0]   hall_s1;
  logic [2:0]   hall_s2;
  logic [2:0]   hall_code;
  phase_state_t st_u;
  phase_state_t st_v;
  phase_state_t st_w;
  logic         illegal;

  pwm_gen #(
    .PWM_W(PWM_W)
  ) u_pwm_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .duty     (duty),
    .pwm      (pwm),
    .pwm_sync (pwmSync)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hall_s1 <= '0;
      hall_s2 <= '0;
    end else begin
      hall_s1 <= {hallGrn, hallYel, hallBlu};
      hall_s2 <= hall_s1;
    end
  end

`ifdef HALL_DEBOUNCE_EN
  logic [1:0] stab;

  // stab counts consecutive cycles with hall_s1 == hall_s2; at 3 the value
  // in hall_s2 has been held for 4 clocks and is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stab      <= '0;
      hall_code <= '0;
    end else begin
      if (hall_s1 != hall_s2) begin
        stab <= '0;
      end else if (stab != 2'd3) begin
        stab <= stab + 2'd1;
      end
      if (stab == 2'd3) begin
        hall_code <= hall_s2;
      end
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hall_code <= '0;
    end else begin
      hall_code <= hall_s2;
    end
  end
`endif

  always_comb begin
    st_u    = HIZ;
    st_v    = HIZ;
    st_w    = HIZ;
    illegal = 1'b0;
    case (hall_code)
      HALL_S1: begin st_u = FWD; st_v = REV; end
      HALL_S2: begin st_u = FWD; st_w = REV; end
      HALL_S3: begin st_v = FWD; st_w = REV; end
      HALL_S4: begin st_u = REV; st_v = FWD; end
      HALL_S5: begin st_u = REV; st_w = FWD; end
      HALL_S6: begin st_v = REV; st_w = FWD; end
      default: illegal = 1'b1;
    endcase
    if (!brake_n) begin
      st_u = BRK;
      st_v = BRK;
      st_w = BRK;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {highU, lowU} <= '0;
      {highV, lowV} <= '0;
      {highW, lowW} <= '0;
      hallErr       <= 1'b1;
    end else begin
      {highU, lowU} <= phase_drive(st_u, pwm);
      {highV, lowV} <= phase_drive(st_v, pwm);
      {highW, lowW} <= phase_drive(st_w, pwm);
      hallErr       <= illegal;
    end
  end

endmodule

// File: tb/tb_phase_drive_gen.sv
// Self-checking bench for phase_drive_gen: a period/latency model computed
// from cycle index arithmetic, checked on every cycle, plus literal pins.
module tb_phase_drive_gen;

  localparam int PERIOD = 2048;

  logic        clk;
  logic        rst_n;
  logic [10:0] duty;
  logic        hallGrn, hallYel, hallBlu;
  logic        brake_n;
  logic        highU, lowU, highV, lowV, highW, lowW;
  logic        pwmSync, hallErr;

  phase_drive_gen #(.PWM_W(11)) dut (
    .clk(clk), .rst_n(rst_n), .duty(duty),
    .hallGrn(hallGrn), .hallYel(hallYel), .hallBlu(hallBlu),
    .brake_n(brake_n),
    .highU(highU), .lowU(lowU), .highV(highV), .lowV(lowV),
    .highW(highW), .lowW(lowW), .pwmSync(pwmSync), .hallErr(hallErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Input history indexed by clock edge number since reset release.
  logic [2:0]  hall_h [0:32767];
  logic [10:0] duty_h [0:32767];

  // Hall code the output stage uses at edge n.
  function automatic logic [2:0] hall_at(input int n);
`ifdef HALL_DEBOUNCE_EN
    for (int j = n - 6; j >= 0; j--) begin
      if (hall_h[j] == hall_h[j+1] && hall_h[j] == hall_h[j+2] && hall_h[j] == hall_h[j+3])
        return hall_h[j];
    end
    return 3'b000;
`else
    return (n < 3) ? 3'b000 : hall_h[n-3];
`endif
  endfunction

  function automatic logic [5:0] exp_gates(input logic [2:0] hc, input logic br, input logic p);
    string st;
    logic [5:0] g;
    g = '0;
    if (!br) st = "BBB";
    else case (hc)
      3'b101: st = "FRZ";
      3'b100: st = "FZR";
      3'b110: st = "ZFR";
      3'b010: st = "RFZ";
      3'b011: st = "RZF";
      3'b001: st = "ZRF";
      default: st = "ZZZ";
    endcase
    for (int unsigned i = 0; i < 3; i++) begin
      logic [1:0] hl;
      case (st[i])
        "F": hl = {p, ~p};
        "R": hl = {~p, p};
        "B": hl = {1'b0, p};
        default: hl = 2'b00;
      endcase
      g[5-2*i -: 2] = hl;
    end
    return g;
  endfunction

  int   n = 0;
  int   hu [0:7];
  int   lu [0:7];
  bit   first_run = 1'b1;
  int   last_sync = -1;
  logic br_now;

  initial for (int i = 0; i < 8; i++) begin hu[i] = 0; lu[i] = 0; end

  always @(posedge clk) begin
    if (!rst_n) begin
      n = 0;
      last_sync = -1;
    end else begin
      int p, c, dl;
      logic pw;
      logic [2:0] hc;
      logic [7:0] expv, actv;
      hall_h[n] = {hallGrn, hallYel, hallBlu};
      duty_h[n] = duty;
      br_now    = brake_n;
      #1;
      p  = n / PERIOD;
      c  = n % PERIOD;
      dl = (p == 0) ? 0 : int'(duty_h[p*PERIOD-1]);
      pw = (c < dl);
      hc = hall_at(n);
      expv = {exp_gates(hc, br_now, pw), (c == 0), (hc == 3'b000 || hc == 3'b111)};
      actv = {highU, lowU, highV, lowV, highW, lowW, pwmSync, hallErr};
      chk("outputs", 32'(actv), 32'(expv));
      chk("shoot_through", 32'((highU & lowU) | (highV & lowV) | (highW & lowW)), 32'd0);
      if (first_run && p < 8) begin
        hu[p] += int'(highU);
        lu[p] += int'(lowU);
        if (pwmSync) begin
          if (last_sync >= 0) chk("sync_period", 32'(n - last_sync), 32'd2048);
          last_sync = n;
        end
      end
      n++;
    end
  end

  int drv_n = 0;
  task automatic go_to(input int m);
    while (drv_n < m) begin
      @(negedge clk);
      drv_n++;
    end
  endtask

  task automatic set_hall(input logic [2:0] h);
    {hallGrn, hallYel, hallBlu} = h;
  endtask

  initial begin
    logic [2:0] seq [0:5];
    seq[0] = 3'b101; seq[1] = 3'b100; seq[2] = 3'b110;
    seq[3] = 3'b010; seq[4] = 3'b011; seq[5] = 3'b001;

    rst_n = 1'b0; duty = 11'd1024; set_hall(3'b101); brake_n = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    chk("reset_gates", 32'({highU, lowU, highV, lowV, highW, lowW, pwmSync}), 32'd0);
    chk("reset_hallerr", 32'(hallErr), 32'd1);
    @(negedge clk);
    rst_n = 1'b1; duty = 11'd512; drv_n = 0;

    // Reload at cnt = 700 of period 2 must only affect period 3.
    go_to(2*PERIOD + 700); duty = 11'd1500;
    go_to(7000);           duty = 11'd2047;
    go_to(9000);           duty = 11'd0;
    go_to(6*PERIOD + 20);
    chk("on_cnt_p0", 32'(hu[0]), 32'd0);
    chk("on_cnt_p1", 32'(hu[1]), 32'd512);
    chk("low_cnt_p1", 32'(lu[1]), 32'd1536);
    chk("on_cnt_p2", 32'(hu[2]), 32'd512);
    chk("on_cnt_p3", 32'(hu[3]), 32'd1500);
    chk("on_cnt_p4", 32'(hu[4]), 32'd2047);
    chk("on_cnt_p5", 32'(hu[5]), 32'd0);
    duty = 11'd900;

    for (int i = 0; i < 6; i++) begin
      set_hall(seq[i]);
      go_to(drv_n + 300);
    end

    // Short glitch then a 4-cycle change.
    set_hall(3'b101); go_to(drv_n + 50);
    set_hall(3'b100); go_to(drv_n + 2);
    set_hall(3'b101); go_to(drv_n + 50);
    set_hall(3'b100); go_to(drv_n + 4);
    set_hall(3'b101); go_to(drv_n + 50);

    set_hall(3'b111); go_to(drv_n + 50);
    #1;
    chk("illegal_gates", 32'({highU, lowU, highV, lowV, highW, lowW}), 32'd0);
    chk("illegal_err", 32'(hallErr), 32'd1);
    brake_n = 1'b0;
    go_to(drv_n + 10);
    #1;
    chk("brake_highs", 32'({highU, highV, highW}), 32'd0);
    chk("brake_err", 32'(hallErr), 32'd1);
    go_to(drv_n + 300);
    brake_n = 1'b1;
    set_hall(3'b000); go_to(drv_n + 100);

    for (int i = 0; i < 400; i++) begin
      set_hall(3'($urandom_range(0, 7)));
      if ($urandom_range(0, 9) < 3) begin
        int r;
        r = $urandom_range(0, 9);
        duty = (r == 0) ? 11'd0 : (r == 1) ? 11'd2047 : 11'($urandom_range(0, 2047));
      end
      brake_n = ($urandom_range(0, 9) != 0);
      go_to(drv_n + $urandom_range(1, 40));
    end

    // Asynchronous reset in the middle of a period.
    brake_n = 1'b1; set_hall(3'b110); duty = 11'd300;
    go_to(drv_n + 123);
    #2 rst_n = 1'b0;
    first_run = 1'b0;
    #1;
    chk("async_rst_gates", 32'({highU, lowU, highV, lowV, highW, lowW, pwmSync}), 32'd0);
    chk("async_rst_err", 32'(hallErr), 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1; drv_n = 0;
    for (int i = 0; i < 60; i++) begin
      set_hall(3'($urandom_range(0, 7)));
      brake_n = ($urandom_range(0, 7) != 0);
      go_to(drv_n + $urandom_range(1, 40));
    end
    go_to(drv_n + 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/phase_drive_gen.md
# phase_drive_gen

Generates the six raw gate-drive signals (high/low per phase U, V, W) for the e-bike brushless motor from a duty command and the three hall sensors. It combines an 11-bit PWM generator with six-step hall commutation and a brake mode. Its outputs feed the per-phase dead-time insertion stages directly. Dead time is not inserted here.

## Interface
- PWM_W, 11, width of PWM counter and duty command
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous active-low reset
- duty  in  PWM_W  duty command; high-side on-count per PWM period
- hallGrn, hallYel, hallBlu  in  1 each  raw asynchronous hall sensor inputs
- brake_n  in  1  active-low brake request, synchronous to clk
- highU, lowU, highV, lowV, highW, lowW  out  1 each  registered raw gate commands to the dead-time stages
- pwmSync  out  1  one-cycle pulse on the first cycle of each PWM period
- hallErr  out  1  high while the hall code is illegal (000 or 111)

## Operation
- PWM counter cnt (PWM_W bits) increments every clk and wraps 2^PWM_W−1 → 0.
- duty is captured into dutyL when cnt == 2^PWM_W−1, so a new value takes effect from cnt == 0. There are no mid-period duty changes.
- pwm = (cnt < dutyL), unsigned compare.
  - duty = 0 gives pwm permanently low.
  - duty = 2047 gives pwm high for 2047 of 2048 cycles.
- Hall inputs pass through two flip-flops each (metastability), then a code register hallCode = {G,Y,B}.
- Each phase is in exactly one state:
  - FWD: high = pwm, low = ~pwm
  - REV: high = ~pwm, low = pwm
  - HIZ: high = 0, low = 0
  - BRK: high = 0, low = pwm
- Commutation from hallCode:
  - 101: U FWD, V REV, W HIZ
  - 100: U FWD, V HIZ, W REV
  - 110: U HIZ, V FWD, W REV
  - 010: U REV, V FWD, W HIZ
  - 011: U REV, V HIZ, W FWD
  - 001: U HIZ, V REV, W FWD
  - 000, 111: all HIZ and hallErr = 1
- Priority: brake_n == 0 overrides commutation, giving all phases BRK, including when the hall code is illegal.
- The high and low of the same phase are never both 1 in any cycle, for every state.

## Timing
- Reset values: all six gate outputs 0, pwmSync 0, hallErr 1.
  - Reset clears the sync flops and hallCode to 000, so all phases are HIZ.
  - cnt and dutyL reset to 0.
- Reset asserted mid-period forces all outputs to 0 immediately, asynchronously. After release, cnt restarts at 0.
- Gate outputs are registered: they reflect pwm/state computed from cnt one cycle earlier.
- pwmSync is asserted in the cycle the outputs correspond to cnt == 0.
- Hall latency: a hall edge sampled at clock edge k updates hallCode at edge k+2 and the gate outputs at edge k+3.
- brake_n latency: 1 cycle. The change is visible on the outputs at the edge after brake_n is sampled.
- A hall change and a duty reload in the same cycle are independent; both take effect on their own paths.

## Configuration
- HALL_DEBOUNCE_EN defined:
  - A synchronized hall code must be identical for 4 consecutive clks before it is loaded into hallCode. A 2-bit stability counter resets on any change.
  - Hall-to-output latency becomes 6 cycles minimum.
  - Glitches shorter than 4 clks are ignored.
- HALL_DEBOUNCE_EN undefined: the synchronized code loads into hallCode every cycle, with the latency given in Timing.

## Structure
- Package motor_pkg:
  - phase_state_t enum {FWD, REV, HIZ, BRK}
  - PWM_W default constant
  - the six legal hall code constants
- Sub-module pwm_gen: cnt, dutyL reload, pwm and pwmSync generation.
- Commutation decode and output registers live in phase_drive_gen.

## Test plan
- Reset: hold rst_n = 0 with hall = 101, duty = 1024 → all gates 0, hallErr = 1. After release, the outputs follow 101 within 3 cycles plus debounce.
- PWM: duty = 512, hall = 101 → highU high 512/2048 cycles, lowU the complement, highV = lowU, W both 0. pwmSync period = 2048.
- Duty reload: change duty 512 → 1500 at cnt = 700 → the current period still uses 512, the next period uses 1500.
- Commutation: step hall through 101, 100, 110, 010, 011, 001 → each phase state matches the table with the specified latency. Never high & low on the same phase.
- Illegal/brake: hall = 111 → all 0 and hallErr = 1. Then brake_n = 0 → lowU/V/W = pwm and all highs 0.
- Debounce (HALL_DEBOUNCE_EN): a 2-cycle hall glitch 101 → 100 → 101 → no output change. A 4-cycle-stable change is accepted.
